// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Widest request mask the round-robin helper handles.
  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 5;

  // Occupancy counter must be able to hold the value FIFO_SIZE itself.
  function automatic int count_w(input int fifo_size);
    return $clog2(fifo_size + 1);
  endfunction

  // Requester index width, at least one bit.
  function automatic int id_w(input int n_req);
    return ($clog2(n_req) < 1) ? 1 : $clog2(n_req);
  endfunction

  // First set bit of mask searching upward from ptr+1 with wrap modulo n.
  // Returns ptr when the mask is empty, so the caller must qualify with |mask.
  function automatic int rr_next(input logic [RR_MAX-1:0] mask, input int ptr, input int n);
    int idx;
    int sel;
    sel = ptr;
    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    for (int k = n; k >= 1; k--) begin
      idx = (ptr + k) % n;
      if (mask[idx[RR_IDX_W-1:0]]) sel = idx;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin priority picker: next requester after last_grant.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [ID_W-1:0]  grant,
  output logic             any_req
);

  logic [RR_MAX-1:0] mask_ext;

  // Widen the request mask to the helper width and run the wrap search.
  always_comb begin
    mask_ext = RR_MAX'(req);
    grant    = ID_W'(rr_next(mask_ext, int'(last_grant), N_REQ));
    any_req  = |req;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-granular arbiter sharing one FIFO write port between
// N_REQ valid/ready producers, with occupancy tracked from write/read strobes.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int FIFO_SIZE = 8,
  parameter int MAX_BURST = 4,
  localparam int COUNT_W  = count_w(FIFO_SIZE),
  localparam int ID_W     = id_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    fifo_write,
  output logic [DATA_W-1:0]       fifo_data_in,
  input  logic                    fifo_read,
  output logic [COUNT_W-1:0]      fifo_count,
  output logic                    fifo_full,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);

  localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_t        state;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   pick_id;
  logic [BEAT_W-1:0] beat_cnt;
  logic              any_req;
  logic              beat;
  logic              eff_read;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_id),
    .any_req    (any_req)
  );

  // Full is taken from the registered count, so a same-cycle read never frees space early.
  assign busy       = (state == GRANT);
  assign fifo_full  = (fifo_count == COUNT_W'(FIFO_SIZE));
  assign beat       = busy && req_valid[grant_id] && !fifo_full;
  assign fifo_write = beat;
  assign eff_read   = fifo_read && (fifo_count != '0);

  // Only the current owner sees ready, and only while there is room.
  always_comb begin
    req_ready = '0;
    if (busy && !fifo_full) req_ready[grant_id] = 1'b1;
  end

  // Owner's data passes straight through on a beat, zero otherwise.
  always_comb begin
    fifo_data_in = '0;
    if (beat) fifo_data_in = req_data[grant_id*DATA_W +: DATA_W];
  end

  // Grant FSM: arbitrate in IDLE, hold the owner until last beat or burst limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req && !fifo_full) begin
            grant_id   <= pick_id;
            last_grant <= pick_id;
            beat_cnt   <= '0;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (req_last[grant_id] || (beat_cnt == BEAT_W'(MAX_BURST - 1))) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Occupancy: writes add, reads of a non-empty FIFO subtract, both together cancel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_count <= '0;
    end else if (fifo_write && !eff_read) begin
      fifo_count <= fifo_count + 1'b1;
    end else if (!fifo_write && eff_read) begin
      fifo_count <= fifo_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: constant vector table, directed
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_fifo_write_arbiter;

  localparam int N_REQ     = 4;
  localparam int DATA_W    = 8;
  localparam int FIFO_SIZE = 8;
  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        fifo_write;
  logic [7:0]  fifo_data_in;
  logic        fifo_read = 1'b0;
  logic [3:0]  fifo_count;
  logic        fifo_full;
  logic [1:0]  grant_id;
  logic        busy;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .N_REQ     (N_REQ),
    .DATA_W    (DATA_W),
    .FIFO_SIZE (FIFO_SIZE),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_write   (fifo_write),
    .fifo_data_in (fifo_data_in),
    .fifo_read    (fifo_read),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: owner index (-1 = none), last winner, beats this grant, FIFO contents.
  int         m_owner;
  int         m_last;
  int         m_beats;
  logic [7:0] m_q[$];

  task automatic model_reset();
    m_owner = -1;
    m_last  = N_REQ - 1;
    m_beats = 0;
    m_q.delete();
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic step(input logic rst_i, input logic [3:0] v, input logic [3:0] l,
                      input logic [31:0] d, input logic rd);
    logic       full_e;
    logic       wr_e;
    logic [3:0] rdy_e;
    logic [7:0] dat_e;
    int         cand;
    @(negedge clk);
    reset     = rst_i;
    req_valid = v;
    req_last  = l;
    req_data  = d;
    fifo_read = rd;
    #1;
    if (!rst_i) begin
      model_reset();
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_write", 32'(fifo_write), 32'd0);
      check("rst_data", 32'(fifo_data_in), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_full", 32'(fifo_full), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_gid", 32'(grant_id), 32'd0);
    end else begin
      full_e = (m_q.size() == FIFO_SIZE);
      rdy_e  = '0;
      wr_e   = 1'b0;
      dat_e  = '0;
      if (m_owner >= 0 && !full_e) begin
        rdy_e = 4'(1 << m_owner);
        wr_e  = v[m_owner[1:0]];
        if (wr_e) dat_e = 8'(d >> (m_owner * 8));
      end
      check("m_ready", 32'(req_ready), 32'(rdy_e));
      check("m_write", 32'(fifo_write), 32'(wr_e));
      check("m_data", 32'(fifo_data_in), 32'(dat_e));
      check("m_count", 32'(fifo_count), 32'(m_q.size()));
      check("m_full", 32'(fifo_full), 32'(full_e));
      check("m_busy", 32'(busy), 32'(m_owner >= 0));
      if (m_owner >= 0) check("m_gid", 32'(grant_id), 32'(m_owner));
      if (rd && m_q.size() != 0) void'(m_q.pop_front());
      if (wr_e) begin
        m_q.push_back(dat_e);
        m_beats++;
        if (l[m_owner[1:0]] || m_beats == MAX_BURST) m_owner = -1;
      end else if (m_owner < 0 && v != 4'd0 && !full_e) begin
        for (int k = 1; k <= N_REQ; k++) begin
          cand = (m_last + k) % N_REQ;
          if (m_owner < 0 && v[cand[1:0]]) m_owner = cand;
        end
        m_last  = m_owner;
        m_beats = 0;
      end
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        rd;
    logic [3:0]  e_rdy;
    logic        e_wr;
    logic [7:0]  e_dat;
    logic [3:0]  e_cnt;
    logic        e_busy;
    logic [1:0]  e_gid;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] l,
                              input logic [31:0] d, input logic rd, input logic [3:0] rdy,
                              input logic wr, input logic [7:0] dat, input logic [3:0] cnt,
                              input logic bsy, input logic [1:0] gid);
    vec_t r;
    r.rst = rst; r.v = v; r.l = l; r.d = d; r.rd = rd;
    r.e_rdy = rdy; r.e_wr = wr; r.e_dat = dat; r.e_cnt = cnt; r.e_busy = bsy; r.e_gid = gid;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [31:0] dall;
    dall = 32'h13121110;

    // Single requester 0, four beats, last on the fourth.
    tbl.push_back(mk(0, 4'hF, 4'h0, 32'h0,  0, 4'h0, 0, 8'h00, 4'd0, 0, 2'd0));
    tbl.push_back(mk(1, 4'h1, 4'h0, 32'hFF, 0, 4'h0, 0, 8'h00, 4'd0, 0, 2'd0));
    tbl.push_back(mk(1, 4'h1, 4'h0, 32'hFF, 0, 4'h1, 1, 8'hFF, 4'd0, 1, 2'd0));
    tbl.push_back(mk(1, 4'h1, 4'h0, 32'h00, 0, 4'h1, 1, 8'h00, 4'd1, 1, 2'd0));
    tbl.push_back(mk(1, 4'h1, 4'h0, 32'hF0, 0, 4'h1, 1, 8'hF0, 4'd2, 1, 2'd0));
    tbl.push_back(mk(1, 4'h1, 4'h1, 32'h0F, 0, 4'h1, 1, 8'h0F, 4'd3, 1, 2'd0));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0,  0, 4'h0, 0, 8'h00, 4'd4, 0, 2'd0));
    // All four valid with one-beat packets: 0,1,2,3,0 with a bubble between.
    tbl.push_back(mk(0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 4'd0, 0, 2'd0));
    tbl.push_back(mk(1, 4'hF, 4'hF, dall,  0, 4'h0, 0, 8'h00, 4'd0, 0, 2'd0));
    tbl.push_back(mk(1, 4'hF, 4'hF, dall,  0, 4'h1, 1, 8'h10, 4'd0, 1, 2'd0));
    tbl.push_back(mk(1, 4'hF, 4'hF, dall,  0, 4'h0, 0, 8'h00, 4'd1, 0, 2'd0));
    tbl.push_back(mk(1, 4'hF, 4'hF, dall,  0, 4'h2, 1, 8'h11, 4'd1, 1, 2'd1));
    tbl.push_back(mk(1, 4'hF, 4'hF, dall,  0, 4'h0, 0, 8'h00, 4'd2, 0, 2'd0));
    tbl.push_back(mk(1, 4'hF, 4'hF, dall,  0, 4'h4, 1, 8'h12, 4'd2, 1, 2'd2));
    tbl.push_back(mk(1, 4'hF, 4'hF, dall,  0, 4'h0, 0, 8'h00, 4'd3, 0, 2'd0));
    tbl.push_back(mk(1, 4'hF, 4'hF, dall,  0, 4'h8, 1, 8'h13, 4'd3, 1, 2'd3));
    tbl.push_back(mk(1, 4'hF, 4'hF, dall,  0, 4'h0, 0, 8'h00, 4'd4, 0, 2'd0));
    tbl.push_back(mk(1, 4'hF, 4'hF, dall,  0, 4'h1, 1, 8'h10, 4'd4, 1, 2'd0));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 4'd5, 0, 2'd0));
    // Write and read together at count 5.
    tbl.push_back(mk(1, 4'h2, 4'h2, 32'h2100, 0, 4'h0, 0, 8'h00, 4'd5, 0, 2'd0));
    tbl.push_back(mk(1, 4'h2, 4'h2, 32'h2100, 1, 4'h2, 1, 8'h21, 4'd5, 1, 2'd1));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0,    0, 4'h0, 0, 8'h00, 4'd5, 0, 2'd0));
    // Read while empty.
    tbl.push_back(mk(0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 4'd0, 0, 2'd0));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0, 1, 4'h0, 0, 8'h00, 4'd0, 0, 2'd0));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 4'd0, 0, 2'd0));

    model_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].rd);
      check("tbl_ready", 32'(req_ready), 32'(tbl[i].e_rdy));
      check("tbl_write", 32'(fifo_write), 32'(tbl[i].e_wr));
      check("tbl_data", 32'(fifo_data_in), 32'(tbl[i].e_dat));
      check("tbl_count", 32'(fifo_count), 32'(tbl[i].e_cnt));
      check("tbl_full", 32'(fifo_full), 32'(tbl[i].e_cnt == 4'd8));
      check("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
      if (tbl[i].e_busy || !tbl[i].rst) check("tbl_gid", 32'(grant_id), 32'(tbl[i].e_gid));
    end

    // Requesters 1 and 3 stream without last: grants broken every MAX_BURST beats.
    step(0, 4'h0, 4'h0, 32'h0, 0);
    for (int c = 0; c < 12; c++) begin
      step(1, 4'b1010, 4'h0, $urandom, 1'b1);
      check("burst_busy", 32'(busy), 32'((c % 5) != 0));
      if (c == 1)  check("burst_gid_a", 32'(grant_id), 32'd1);
      if (c == 6)  check("burst_gid_b", 32'(grant_id), 32'd3);
      if (c == 11) check("burst_gid_c", 32'(grant_id), 32'd1);
    end

    // Fill to eight with no reads, stall the owner, then free one entry.
    step(0, 4'h0, 4'h0, 32'h0, 0);
    for (int c = 0; c < 15; c++) begin
      step(1, 4'h1, {3'b000, c == 3}, $urandom, c == 13);
      if (c == 11 || c == 12) begin
        check("full_flag", 32'(fifo_full), 32'd1);
        check("full_ready", 32'(req_ready), 32'd0);
        check("full_write", 32'(fifo_write), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
      end
      if (c == 13) check("full_rd_cnt", 32'(fifo_count), 32'd8);
      if (c == 14) begin
        check("free_count", 32'(fifo_count), 32'd7);
        check("free_full", 32'(fifo_full), 32'd0);
        check("free_write", 32'(fifo_write), 32'd1);
        check("free_ready", 32'(req_ready), 32'd1);
      end
    end

    // Asynchronous reset in the middle of requester 2's burst at count 3.
    step(0, 4'h0, 4'h0, 32'h0, 0);
    for (int c = 0; c < 4; c++) step(1, 4'h4, 4'h0, $urandom, 1'b0);
    @(posedge clk);
    #1;
    check("mid_count", 32'(fifo_count), 32'd3);
    check("mid_busy", 32'(busy), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_write", 32'(fifo_write), 32'd0);
    check("async_count", 32'(fifo_count), 32'd0);
    check("async_ready", 32'(req_ready), 32'd0);
    model_reset();
    step(0, 4'b0101, 4'h0, 32'h0, 0);
    step(1, 4'b0101, 4'h0, 32'h0, 0);
    step(1, 4'b0101, 4'h0, 32'h00AA00BB, 0);
    check("post_rst_busy", 32'(busy), 32'd1);
    check("post_rst_gid", 32'(grant_id), 32'd0);
    check("post_rst_data", 32'(fifo_data_in), 32'hBB);

    // Randomized traffic, occasional resets, checked against the model each cycle.
    step(0, 4'h0, 4'h0, 32'h0, 0);
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 199) != 0, 4'($urandom), 4'($urandom & $urandom),
           $urandom, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin scheduler that shares the single write port of the FIFO_buffer (FIFO_SIZE, DATA_W) between N_REQ producers using valid/ready handshakes.
- Tracks FIFO occupancy from the write and read strobes, so the FIFO is never written when full.
- Grants are packet-granular: bounded by a last flag or by MAX_BURST beats.
- Sits directly in front of FIFO_buffer in the Axi4 datapath; the FIFO read side remains owned by the consumer.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- DATA_W, 8, data width; must match FIFO_buffer DATA_W.
- FIFO_SIZE, 8, FIFO depth in entries; must match FIFO_buffer FIFO_SIZE.
- MAX_BURST, 4, maximum beats per grant before forced re-arbitration (>=1).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester data valid.
- req_data  in  N_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  N_REQ  final beat of the requester's packet.
- req_ready  out  N_REQ  per-requester accept.
- fifo_write  out  1  write strobe to FIFO_buffer.write.
- fifo_data_in  out  DATA_W  to FIFO_buffer.data_in.
- fifo_read  in  1  copy of the read strobe driven into FIFO_buffer.read.
- fifo_count  out  COUNT_W  tracked occupancy.
- fifo_full  out  1  fifo_count == FIFO_SIZE.
- grant_id  out  ID_W  index of the current owner (valid while busy).
- busy  out  1  a grant is active.

Behaviour:
- Derived widths: COUNT_W = $clog2(FIFO_SIZE+1); ID_W = max(1, $clog2(N_REQ)).
- Reset (reset low, asynchronous, any state including mid-burst): the FSM goes to IDLE; fifo_count=0, fifo_full=0, busy=0, grant_id=0, beat_cnt=0, last_grant=N_REQ-1 (so requester 0 wins first). While reset is held, fifo_write=0 and req_ready=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - busy=0, req_ready all 0, fifo_write=0.
  - If any req_valid and !fifo_full: pick the first valid index searching from last_grant+1 upward with wrap modulo N_REQ.
  - Register grant_id and last_grant to that index, clear beat_cnt, enter GRANT.
  - Arbitration latency is 1 cycle from valid to the first possible accept.
- GRANT:
  - busy=1.
  - req_ready[grant_id] = !fifo_full; all other ready bits are 0.
  - Beat = req_valid[g] & req_ready[g]. On a beat, fifo_write=1 in the same cycle and fifo_data_in = req_data slice g (combinational pass-through, zero latency). beat_cnt increments.
  - Exit to IDLE after a beat with req_last[g]=1, or a beat with beat_cnt==MAX_BURST-1.
  - If the owner deasserts valid, the grant is held with no timeout; the owner must finish its packet.
- fifo_data_in is 0 when fifo_write=0.
- Re-arbitration bubble: one IDLE cycle between grants is required, so there are no back-to-back grants.
- Occupancy:
  - eff_read = fifo_read & (fifo_count != 0).
  - fifo_count next = count + fifo_write - eff_read.
  - A simultaneous write and read leaves the count unchanged.
  - A read when empty is ignored.
  - Write when full is impossible because ready is gated by the registered fifo_full. A same-cycle read does not free space early; this is conservative.
- Round-robin fairness: a requester continuously valid is granted within N_REQ-1 grants of other requesters.
- Starvation on full: in GRANT with fifo_full, the owner stalls; the grant is retained until space appears.

Decomposition:
- Shared package fifo_arb_pkg:
  - state enum {IDLE, GRANT};
  - function clog2-based width helpers (COUNT_W, ID_W);
  - rr_next function (mask, pointer -> index).
- Sub-module rr_pick (combinational N_REQ-wide round-robin priority picker: req mask, last_grant -> grant index, any_req). This isolates the wrap search so it can be reused by the read-side scheduler.

Test Plan:
- Reset then single requester 0 sends 4 beats 0xFF,0x00,0xF0,0x0F with last on the 4th -> grant_id=0, busy=1 one cycle after valid. fifo_write asserts on 4 consecutive cycles with matching fifo_data_in. fifo_count = 4, then busy=0.
- All 4 requesters valid with 1-beat packets (last=1) -> grants in order 0,1,2,3,0 with one idle cycle between. Each req_ready asserts only for its owner.
- Requester 1 streams 10 beats with no last and MAX_BURST=4 -> grant is broken after beats 4 and 8. Other requesters that are valid interleave. fifo_count never exceeds 8.
- Fill to 8 with no reads -> fifo_full=1, req_ready=0, fifo_write=0 while the owner's valid stays high. A single fifo_read pulse gives count 7, full=0 next cycle, and one more beat accepted.
- Simultaneous fifo_write and fifo_read at count 5 -> count stays 5. fifo_read at count 0 -> count stays 0.
- Assert reset (low) mid-burst at count 3 -> immediately busy=0, fifo_write=0, fifo_count=0. After release, requester 0 is granted first.
